// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : warp_scheduler
// Purpose  : Per-core round-robin issue scheduler. Offers one ready, active
//            warp per cycle to the issue stage over a valid/accept handshake,
//            tracks warp exits and raises done once every launched warp exits.
// Revision : 1.0 - initial release
// ============================================================================
module warp_scheduler #(
  parameter int WARPS_PER_CORE = 4,
  parameter int WARP_ID_WIDTH  = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WARP_ID_WIDTH:0]     num_warps,
  input  logic [WARPS_PER_CORE-1:0]  warp_ready,
  input  logic [WARPS_PER_CORE-1:0]  warp_exit,
  output logic                       issue_valid,
  output logic [WARP_ID_WIDTH-1:0]   issue_warp,
  input  logic                       issue_accept,
  output logic [WARPS_PER_CORE-1:0]  active_mask,
  output logic                       done,
  output logic [COUNT_WIDTH-1:0]     issue_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Pointer starts at the last slot so that warp 0 is searched first.
  localparam logic [WARP_ID_WIDTH-1:0] PTR_INIT = WARP_ID_WIDTH'(WARPS_PER_CORE - 1);

  logic [1:0]                state;
  logic [WARP_ID_WIDTH-1:0]  ptr;

  logic                      accepted;
  logic [WARP_ID_WIDTH-1:0]  search_base;
  logic [WARPS_PER_CORE-1:0] cand;
  logic [WARPS_PER_CORE-1:0] cand_shift;
  logic [WARPS_PER_CORE-1:0] exit_shift;
  logic                      offered_exits;
  logic                      found;
  logic [WARP_ID_WIDTH-1:0]  grant;
  logic [WARPS_PER_CORE-1:0] launch_mask;
  logic [WARPS_PER_CORE-1:0] next_mask;

  // Candidate set, round-robin search and launch mask decode.
  always_comb begin
    accepted    = issue_valid & issue_accept;
    // After an accept the search continues past the warp just taken, so the
    // next offer in the following cycle already honours round-robin order.
    search_base = accepted ? issue_warp : ptr;
    cand        = active_mask & warp_ready & ~warp_exit;
    // The accepted warp still shows ready this cycle; its ready only drops
    // one cycle later, so it must not be granted again right away.
    if (accepted) begin
      cand = cand & ~(WARPS_PER_CORE'(1) << issue_warp);
    end
    exit_shift    = warp_exit >> issue_warp;
    offered_exits = exit_shift[0];
    next_mask     = active_mask & ~warp_exit;

    found      = 1'b0;
    grant      = '0;
    cand_shift = '0;
    for (int k = 1; k <= WARPS_PER_CORE; k++) begin
      cand_shift = cand >> ((int'(search_base) + k) % WARPS_PER_CORE);
      if (!found && cand_shift[0]) begin
        found = 1'b1;
        grant = WARP_ID_WIDTH'((int'(search_base) + k) % WARPS_PER_CORE);
      end
    end

    // Requests above the slot count saturate to all slots.
    launch_mask = '0;
    for (int i = 0; i < WARPS_PER_CORE; i++) begin
      launch_mask[i] = (32'(num_warps) > i);
    end
  end

  // Launch / run / done state machine with registered issue outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= PTR_INIT;
      issue_valid <= 1'b0;
      issue_warp  <= '0;
      active_mask <= '0;
      done        <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            active_mask <= launch_mask;
            issue_count <= '0;
            ptr         <= PTR_INIT;
            issue_valid <= 1'b0;
            issue_warp  <= '0;
            if (num_warps == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          active_mask <= next_mask;
          if (accepted) begin
            ptr         <= issue_warp;
            issue_count <= issue_count + 1'b1;
          end
          if (next_mask == '0) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            issue_valid <= 1'b0;
          end else if (issue_valid && !issue_accept) begin
            // Pending offer holds; only an exit of the offered warp retracts it.
            if (offered_exits) begin
              issue_valid <= 1'b0;
            end
          end else begin
            issue_valid <= found;
            if (found) begin
              issue_warp <= grant;
            end
          end
        end
        ST_DONE: begin
          // Terminal until reset.
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_scheduler
// Purpose  : Directed self-checking bench for warp_scheduler (4 warp slots).
//            Expected grants are queued when stimulus is applied and popped
//            when the scheduler presents an offer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_warp_scheduler;

  localparam int W  = 4;
  localparam int WI = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WI:0]   num_warps;
  logic [W-1:0]  warp_ready;
  logic [W-1:0]  warp_exit;
  logic          issue_valid;
  logic [WI-1:0] issue_warp;
  logic          issue_accept;
  logic [W-1:0]  active_mask;
  logic          done;
  logic [CW-1:0] issue_count;

  int total = 0;
  int bad   = 0;
  int sb[$];

  warp_scheduler #(
    .WARPS_PER_CORE(W),
    .WARP_ID_WIDTH (WI),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_warps   (num_warps),
    .warp_ready  (warp_ready),
    .warp_exit   (warp_exit),
    .issue_valid (issue_valid),
    .issue_warp  (issue_warp),
    .issue_accept(issue_accept),
    .active_mask (active_mask),
    .done        (done),
    .issue_count (issue_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the current offer with the oldest queued expectation.
  task automatic expect_offer(input string tag);
    int e;
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    if (sb.size() == 0) begin
      e = -1;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, "_warp"}, 32'(issue_warp), 32'(e));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
    chk({tag, "_warp"},  32'(issue_warp),  32'd0);
    chk({tag, "_mask"},  32'(active_mask), 32'd0);
    chk({tag, "_done"},  32'(done),        32'd0);
    chk({tag, "_count"}, issue_count,      32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_warps = '0;
    warp_ready = '0; warp_exit = '0; issue_accept = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");

    // --- Round-robin with accept every cycle, three warps ready ---
    reset = 1'b0;
    start = 1'b1; num_warps = 3'd3; warp_ready = 4'b0111; issue_accept = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sb.push_back(0); sb.push_back(1); sb.push_back(2);
    end
    tick();
    start = 1'b0;
    chk("launch_mask", 32'(active_mask), 32'h7);
    chk("launch_no_offer", 32'(issue_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      expect_offer("rr");
      tick();
    end
    issue_accept = 1'b0;
    chk("count_after_six", issue_count, 32'd6);

    // --- Held offer stays stable while its ready drops ---
    issue_accept = 1'b1;          // take the pending warp 0 offer
    tick();
    issue_accept = 1'b0;
    warp_ready = 4'b0100;
    sb.push_back(1);
    expect_offer("hold0");
    tick();
    chk("hold1_valid", 32'(issue_valid), 32'd1);
    chk("hold1_warp",  32'(issue_warp),  32'd1);
    tick();
    chk("hold2_valid", 32'(issue_valid), 32'd1);
    chk("hold2_warp",  32'(issue_warp),  32'd1);
    issue_accept = 1'b1;
    sb.push_back(2);
    tick();
    issue_accept = 1'b0;
    expect_offer("after_hold");
    chk("count_after_hold", issue_count, 32'd8);

    // --- Exit of the offered warp retracts the offer ---
    warp_ready = 4'b0010; issue_accept = 1'b1;
    sb.push_back(1);
    tick();
    issue_accept = 1'b0;
    expect_offer("pre_exit");
    warp_exit = 4'b0010;
    tick();
    warp_exit = '0;
    chk("exit_drop_valid", 32'(issue_valid), 32'd0);
    chk("exit_mask", 32'(active_mask), 32'h5);
    warp_ready = 4'b0111; issue_accept = 1'b1;
    sb.push_back(0); sb.push_back(2); sb.push_back(0);
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_offer("no_w1");
      tick();
    end
    issue_accept = 1'b0; warp_ready = '0;
    chk("count_after_exit", issue_count, 32'd12);

    // --- Remaining exits lead to done; later start ignored ---
    warp_exit = 4'b0001;
    tick();
    chk("exit0_mask", 32'(active_mask), 32'h4);
    chk("exit0_done", 32'(done), 32'd0);
    chk("exit0_valid", 32'(issue_valid), 32'd1);
    warp_exit = 4'b0110;
    tick();
    warp_exit = '0;
    chk("fin_mask", 32'(active_mask), 32'h0);
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_valid", 32'(issue_valid), 32'd0);
    start = 1'b1; num_warps = 3'd2;
    tick();
    start = 1'b0;
    tick();
    chk("restart_ign_done", 32'(done), 32'd1);
    chk("restart_ign_mask", 32'(active_mask), 32'h0);
    chk("restart_ign_count", issue_count, 32'd12);

    // --- Zero-warp launch completes immediately ---
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1; num_warps = 3'd0; warp_ready = 4'b1111; issue_accept = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("zero_no_valid", 32'(issue_valid), 32'd0);
      tick();
    end

    // --- Oversized launch saturates to all slots ---
    reset = 1'b1; issue_accept = 1'b0; warp_ready = '0;
    tick();
    reset = 1'b0;
    start = 1'b1; num_warps = 3'd7;
    tick();
    start = 1'b0;
    chk("sat_mask", 32'(active_mask), 32'hF);
    warp_ready = 4'b0001;
    sb.push_back(0);
    tick();
    tick();
    expect_offer("pre_reset");

    // --- Reset mid-run drops the offer and clears everything ---
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    warp_ready = 4'b0011;
    start = 1'b1; num_warps = 3'd2;
    sb.push_back(0);
    tick();
    start = 1'b0;
    chk("relaunch_mask", 32'(active_mask), 32'h3);
    tick();
    expect_offer("relaunch");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
